// File: rtl/sa_skew_feeder_pkg.sv
// Shared types and constants for the systolic-array skew feeder.
// Optional performance counters are enabled with SA_FEED_PERF_CNT_EN.
package sa_pkg;

   localparam int SA_DEFAULT_LANES  = 16;
   localparam int SA_DEFAULT_DATA_W = 16;

   typedef logic [SA_DEFAULT_DATA_W-1:0] lane_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } sa_state_e;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int sa_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Host row stream and array beat stream of the skew feeder.
// The slave modport is the feeder side; master is the host/array side.
interface sa_skew_feeder_if
   import sa_pkg::*;
#(
   parameter int DATA_W = SA_DEFAULT_DATA_W,
   parameter int LANES  = SA_DEFAULT_LANES
);

   logic                    IN_VALID;
   logic                    IN_READY;
   logic [LANES*DATA_W-1:0] IN_DATA;
   logic [LANES*DATA_W-1:0] OUT_DATA;
   logic [LANES-1:0]        OUT_VALID;
   logic                    OUT_READY;

   modport master (
      output IN_VALID, IN_DATA, OUT_READY,
      input  IN_READY, OUT_DATA, OUT_VALID
   );

   modport slave (
      input  IN_VALID, IN_DATA, OUT_READY,
      output IN_READY, OUT_DATA, OUT_VALID
   );

endinterface

// File: rtl/sa_skew_feeder_row_buffer.sv
// DEPTH x LANES operand store: whole-row write, per-lane diagonal read.
// Lane j returns row (beat - j) and flags whether that row exists.
module sa_row_buffer
   import sa_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LANES  = 16,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = sa_idx_w(DEPTH),
   parameter int T_W    = sa_idx_w(DEPTH + LANES)
)(
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [LANES*DATA_W-1:0] wr_data,
   input  logic [T_W-1:0]          rd_beat,
   output logic [LANES*DATA_W-1:0] rd_data,
   output logic [LANES-1:0]        rd_valid
);

   logic [LANES*DATA_W-1:0] mem_q [DEPTH];
   logic [LANES*DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end
   end

   // Contents are deliberately not reset; rows are always written before use.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data  = '0;
      rd_valid = '0;
      for (int j = 0; j < LANES; j++) begin
         if ((int'(rd_beat) >= j) && (int'(rd_beat) - j < DEPTH)) begin
            rd_valid[j]                 = 1'b1;
            rd_data[j*DATA_W +: DATA_W] = mem_q[IDX_W'(int'(rd_beat) - j)][j*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/sa_skew_feeder.sv
// Operand loader/sequencer: buffers DEPTH rows, streams them diagonally skewed,
// drains, then pulses DONE. Define SA_FEED_PERF_CNT_EN for STALL_CNT/FEED_CNT.
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int LANES     = SA_DEFAULT_LANES,
   parameter int DEPTH     = 8,
   parameter int DRAIN_CYC = 16
)(
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       EN,
   input  logic                       CLR,
   sa_skew_feeder_if.slave            bus,
   output logic [sa_idx_w(DEPTH)-1:0] ROW_IDX,
   output logic                       BUSY,
   output logic                       DONE
`ifdef SA_FEED_PERF_CNT_EN
   ,
   output logic [31:0]                STALL_CNT,
   output logic [31:0]                FEED_CNT
`endif
);

   localparam int IDX_W = sa_idx_w(DEPTH);
   localparam int T_W   = sa_idx_w(DEPTH + LANES);
   localparam int DR_W  = sa_idx_w(DRAIN_CYC);

   localparam logic [T_W-1:0]  LAST_BEAT  = T_W'(DEPTH + LANES - 2);
   localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(DRAIN_CYC - 1);

   sa_state_e               state_q, state_d;
   logic [IDX_W-1:0]        row_idx_q, row_idx_d;
   logic [T_W-1:0]          beat_q, beat_d;
   logic [DR_W-1:0]         drain_q, drain_d;
   logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
   logic [LANES-1:0]        out_valid_q, out_valid_d;

   logic                    wr_en;
   logic                    beat_live;
   logic [T_W-1:0]          rd_beat;
   logic [LANES*DATA_W-1:0] rd_data;
   logic [LANES-1:0]        rd_valid;

   // Every presented beat has at least one valid lane, so an all-zero
   // OUT_VALID in FEED means beat 0 has not been loaded yet.
   assign beat_live = |out_valid_q;
   assign rd_beat   = beat_live ? beat_q + 1'b1 : beat_q;

   sa_row_buffer #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .T_W    (T_W)
   ) u_row_buffer (
      .clk      (CLK),
      .wr_en    (wr_en),
      .wr_idx   (row_idx_q),
      .wr_data  (bus.IN_DATA),
      .rd_beat  (rd_beat),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      beat_d      = beat_q;
      drain_d     = drain_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      wr_en       = 1'b0;
      if (EN) begin
         if (CLR) begin
            state_d     = ST_IDLE;
            row_idx_d   = '0;
            beat_d      = '0;
            drain_d     = '0;
            out_data_d  = '0;
            out_valid_d = '0;
         end else begin
            case (state_q)
               ST_IDLE: state_d = ST_LOAD;
               ST_LOAD: begin
                  if (bus.IN_VALID) begin
                     wr_en = 1'b1;
                     if (row_idx_q == IDX_W'(DEPTH - 1)) begin
                        row_idx_d = '0;
                        beat_d    = '0;
                        state_d   = ST_FEED;
                     end else begin
                        row_idx_d = row_idx_q + 1'b1;
                     end
                  end
               end
               ST_FEED: begin
                  if (!beat_live) begin
                     out_data_d  = rd_data;
                     out_valid_d = rd_valid;
                  end else if (bus.OUT_READY) begin
                     if (beat_q == LAST_BEAT) begin
                        out_data_d  = '0;
                        out_valid_d = '0;
                        beat_d      = '0;
                        state_d     = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
                     end else begin
                        beat_d      = beat_q + 1'b1;
                        out_data_d  = rd_data;
                        out_valid_d = rd_valid;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (drain_q == DRAIN_LAST) begin
                     drain_d = '0;
                     state_d = ST_DONE;
                  end else begin
                     drain_d = drain_q + 1'b1;
                  end
               end
               ST_DONE: state_d = ST_IDLE;
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         row_idx_q   <= '0;
         beat_q      <= '0;
         drain_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         row_idx_q   <= row_idx_d;
         beat_q      <= beat_d;
         drain_q     <= drain_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.IN_READY  = (state_q == ST_LOAD);
   assign bus.OUT_DATA  = out_data_q;
   assign bus.OUT_VALID = out_valid_q;
   assign ROW_IDX       = row_idx_q;
   assign BUSY          = (state_q == ST_LOAD) || (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign DONE          = (state_q == ST_DONE);

`ifdef SA_FEED_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] feed_cnt_q, feed_cnt_d;

   // Saturating counters, cleared on the IDLE -> LOAD transition.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      feed_cnt_d  = feed_cnt_q;
      if (EN) begin
         if (!CLR && (state_q == ST_IDLE)) begin
            stall_cnt_d = '0;
            feed_cnt_d  = '0;
         end else if (state_q == ST_FEED) begin
            if (feed_cnt_q != '1) begin
               feed_cnt_d = feed_cnt_q + 1'b1;
            end
            if (beat_live && !bus.OUT_READY && (stall_cnt_q != '1)) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt_q <= '0;
         feed_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         feed_cnt_q  <= feed_cnt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign FEED_CNT  = feed_cnt_q;
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: a small 4-lane/3-row instance and a
// default-parameter instance, with hand-computed beat expectations.
module tb_sa_skew_feeder;

   logic clk = 1'b0;
   logic rst_n;
   logic s_en, s_clr, d_en, d_clr;
   logic [1:0] s_row_idx;
   logic [2:0] d_row_idx;
   logic s_busy, s_done, d_busy, d_done;
`ifdef SA_FEED_PERF_CNT_EN
   logic [31:0] s_stall, s_feed, d_stall, d_feed;
`endif

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_v [6];

   always #5 clk = ~clk;

   sa_skew_feeder_if #(.DATA_W(16), .LANES(4))  s_bus ();
   sa_skew_feeder_if #(.DATA_W(16), .LANES(16)) d_bus ();

   sa_skew_feeder #(.DATA_W(16), .LANES(4), .DEPTH(3), .DRAIN_CYC(2)) u_small (
      .CLK     (clk),
      .RST_N   (rst_n),
      .EN      (s_en),
      .CLR     (s_clr),
      .bus     (s_bus),
      .ROW_IDX (s_row_idx),
      .BUSY    (s_busy),
      .DONE    (s_done)
`ifdef SA_FEED_PERF_CNT_EN
      ,
      .STALL_CNT (s_stall),
      .FEED_CNT  (s_feed)
`endif
   );

   sa_skew_feeder #(.DATA_W(16), .LANES(16), .DEPTH(8), .DRAIN_CYC(16)) u_default (
      .CLK     (clk),
      .RST_N   (rst_n),
      .EN      (d_en),
      .CLR     (d_clr),
      .bus     (d_bus),
      .ROW_IDX (d_row_idx),
      .BUSY    (d_busy),
      .DONE    (d_done)
`ifdef SA_FEED_PERF_CNT_EN
      ,
      .STALL_CNT (d_stall),
      .FEED_CNT  (d_feed)
`endif
   );

   // Expected small-instance beat: lane j carries row (t-j) when that row exists.
   function automatic logic [63:0] exp_small_data(input int t, input logic [15:0] r0,
                                                  input logic [15:0] r1, input logic [15:0] r2);
      logic [15:0] rows [3];
      logic [63:0] res;
      rows = '{r0, r1, r2};
      res  = '0;
      for (int j = 0; j < 4; j++) begin
         if ((t - j >= 0) && (t - j < 3)) res[j*16 +: 16] = rows[t - j];
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_en = 1'b0; s_clr = 1'b0; d_en = 1'b0; d_clr = 1'b0;
      s_bus.IN_VALID = 1'b0; s_bus.IN_DATA = '0; s_bus.OUT_READY = 1'b0;
      d_bus.IN_VALID = 1'b0; d_bus.IN_DATA = '0; d_bus.OUT_READY = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic s_start();
      do_reset();
      s_en = 1'b1;
      tick();
   endtask

   task automatic s_load(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
      s_bus.IN_VALID = 1'b1;
      s_bus.IN_DATA = {4{v0}}; tick();
      s_bus.IN_DATA = {4{v1}}; tick();
      s_bus.IN_DATA = {4{v2}}; tick();
      s_bus.IN_VALID = 1'b0;
   endtask

   // Returns the number of edges since the last-beat edge at which DONE was seen (0 = never).
   task automatic wait_done(input bit dflt, input int limit, output int at);
      at = 0;
      for (int k = 2; k <= limit; k++) begin
         tick();
         if ((dflt ? d_done : s_done) === 1'b1) begin
            at = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if ({s_busy, s_done, s_bus.IN_READY, s_bus.OUT_VALID, s_row_idx} !== '0 || s_bus.OUT_DATA !== '0) begin
         errors++; $display("[TB] FAIL reset_small got busy=%b done=%b rdy=%b vld=%b idx=%0d exp all 0", s_busy, s_done, s_bus.IN_READY, s_bus.OUT_VALID, s_row_idx);
      end
      checks++; if ({d_busy, d_done, d_bus.IN_READY, d_bus.OUT_VALID, d_row_idx} !== '0 || d_bus.OUT_DATA !== '0) begin
         errors++; $display("[TB] FAIL reset_default got busy=%b done=%b rdy=%b vld=%h idx=%0d exp all 0", d_busy, d_done, d_bus.IN_READY, d_bus.OUT_VALID, d_row_idx);
      end
      rst_n = 1'b1;
      tick();
      checks++; if (s_busy !== 1'b0 || s_bus.IN_READY !== 1'b0) begin
         errors++; $display("[TB] FAIL en_low_idle got busy=%b rdy=%b exp 0 0", s_busy, s_bus.IN_READY);
      end
      s_en = 1'b1;
      tick();
      checks++; if (s_busy !== 1'b1 || s_bus.IN_READY !== 1'b1) begin
         errors++; $display("[TB] FAIL idle_to_load got busy=%b rdy=%b exp 1 1", s_busy, s_bus.IN_READY);
      end
   endtask

   task automatic test_basic_feed();
      int at;
      s_start();
      s_bus.OUT_READY = 1'b1;
      s_load(16'd1, 16'd2, 16'd3);
      checks++; if (s_bus.IN_READY !== 1'b0 || s_bus.OUT_VALID !== 4'b0000) begin
         errors++; $display("[TB] FAIL feed_entry got rdy=%b vld=%b exp 0 0000", s_bus.IN_READY, s_bus.OUT_VALID);
      end
      for (int t = 0; t < 6; t++) begin
         tick();
         checks++; if (s_bus.OUT_VALID !== exp_v[t] || s_bus.OUT_DATA !== exp_small_data(t, 1, 2, 3)) begin
            errors++; $display("[TB] FAIL basic_beat t=%0d got %b/%h exp %b/%h", t, s_bus.OUT_VALID, s_bus.OUT_DATA, exp_v[t], exp_small_data(t, 1, 2, 3));
         end
         if (t == 2) begin
            checks++; if (s_bus.OUT_DATA !== {16'd0, 16'd1, 16'd2, 16'd3}) begin
               errors++; $display("[TB] FAIL basic_t2_data got %h exp 0000000100020003", s_bus.OUT_DATA);
            end
         end
      end
      tick();
      checks++; if (s_bus.OUT_VALID !== 4'b0000 || s_bus.OUT_DATA !== '0 || s_busy !== 1'b1) begin
         errors++; $display("[TB] FAIL after_last got vld=%b data=%h busy=%b exp 0000 0 1", s_bus.OUT_VALID, s_bus.OUT_DATA, s_busy);
      end
      wait_done(1'b0, 20, at);
      checks++; if (at !== 3 || s_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_done_time got %0d busy=%b exp 3 0", at, s_busy);
      end
      tick();
      checks++; if (s_done !== 1'b0) begin
         errors++; $display("[TB] FAIL done_one_cycle got %b exp 0", s_done);
      end
   endtask

   task automatic test_stall();
      int at;
      s_start();
      s_bus.OUT_READY = 1'b1;
      s_load(16'd1, 16'd2, 16'd3);
      for (int t = 0; t < 6; t++) begin
         tick();
         checks++; if (s_bus.OUT_VALID !== exp_v[t] || s_bus.OUT_DATA !== exp_small_data(t, 1, 2, 3)) begin
            errors++; $display("[TB] FAIL stall_beat t=%0d got %b/%h exp %b/%h", t, s_bus.OUT_VALID, s_bus.OUT_DATA, exp_v[t], exp_small_data(t, 1, 2, 3));
         end
         if (t == 4) begin
            s_bus.OUT_READY = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick();
               checks++; if (s_bus.OUT_VALID !== 4'b1100 || s_bus.OUT_DATA !== {16'd2, 16'd3, 16'd0, 16'd0}) begin
                  errors++; $display("[TB] FAIL stall_hold k=%0d got %b/%h exp 1100/0002000300000000", k, s_bus.OUT_VALID, s_bus.OUT_DATA);
               end
            end
            s_bus.OUT_READY = 1'b1;
         end
      end
      tick();
`ifdef SA_FEED_PERF_CNT_EN
      checks++; if (s_stall !== 32'd5 || s_feed !== 32'd12) begin
         errors++; $display("[TB] FAIL perf_cnt got stall=%0d feed=%0d exp 5 12", s_stall, s_feed);
      end
`endif
      wait_done(1'b0, 20, at);
      checks++; if (at !== 3) begin
         errors++; $display("[TB] FAIL stall_done_time got %0d exp 3", at);
      end
   endtask

   task automatic test_in_valid_toggle();
      int at;
      int exp_idx;
      s_start();
      s_bus.OUT_READY = 1'b1;
      for (int r = 0; r < 3; r++) begin
         s_bus.IN_VALID = 1'b1;
         s_bus.IN_DATA  = {4{16'(16'h10 + r)}};
         tick();
         exp_idx = (r < 2) ? r + 1 : 0;
         checks++; if (s_row_idx !== 2'(exp_idx)) begin
            errors++; $display("[TB] FAIL toggle_idx r=%0d got %0d exp %0d", r, s_row_idx, exp_idx);
         end
         s_bus.IN_VALID = 1'b0;
         s_bus.IN_DATA  = {4{16'hDEAD}};
         if (r < 2) begin
            tick();
            checks++; if (s_row_idx !== 2'(exp_idx)) begin
               errors++; $display("[TB] FAIL toggle_hold r=%0d got %0d exp %0d", r, s_row_idx, exp_idx);
            end
         end
      end
      tick(); tick(); tick();
      checks++; if (s_bus.OUT_VALID !== 4'b0111 || s_bus.OUT_DATA !== {16'd0, 16'h10, 16'h11, 16'h12}) begin
         errors++; $display("[TB] FAIL toggle_t2 got %b/%h exp 0111/0000001000110012", s_bus.OUT_VALID, s_bus.OUT_DATA);
      end
      tick(); tick(); tick(); tick();
      wait_done(1'b0, 20, at);
      checks++; if (at !== 3) begin
         errors++; $display("[TB] FAIL toggle_done_time got %0d exp 3", at);
      end
   endtask

   task automatic test_clr();
      int at;
      s_start();
      s_bus.OUT_READY = 1'b1;
      s_load(16'd1, 16'd2, 16'd3);
      tick(); tick(); tick(); tick();
      checks++; if (s_bus.OUT_VALID !== 4'b1110) begin
         errors++; $display("[TB] FAIL clr_pre_t3 got %b exp 1110", s_bus.OUT_VALID);
      end
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      checks++; if (s_bus.OUT_VALID !== 4'b0000 || s_bus.OUT_DATA !== '0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
         errors++; $display("[TB] FAIL clr_abort got vld=%b busy=%b done=%b exp 0000 0 0", s_bus.OUT_VALID, s_busy, s_done);
      end
      tick();
      checks++; if (s_busy !== 1'b1 || s_row_idx !== 2'd0 || s_bus.IN_READY !== 1'b1) begin
         errors++; $display("[TB] FAIL clr_reload got busy=%b idx=%0d rdy=%b exp 1 0 1", s_busy, s_row_idx, s_bus.IN_READY);
      end
      s_clr = 1'b1;
      s_bus.IN_VALID = 1'b1;
      s_bus.IN_DATA = {4{16'd99}};
      tick();
      s_clr = 1'b0;
      s_bus.IN_VALID = 1'b0;
      checks++; if (s_row_idx !== 2'd0 || s_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL clr_handshake got idx=%0d busy=%b exp 0 0", s_row_idx, s_busy);
      end
      tick();
      s_load(16'd4, 16'd5, 16'd6);
      for (int t = 0; t < 6; t++) begin
         tick();
         checks++; if (s_bus.OUT_VALID !== exp_v[t] || s_bus.OUT_DATA !== exp_small_data(t, 4, 5, 6)) begin
            errors++; $display("[TB] FAIL clr_refeed t=%0d got %b/%h exp %b/%h", t, s_bus.OUT_VALID, s_bus.OUT_DATA, exp_v[t], exp_small_data(t, 4, 5, 6));
         end
      end
      tick();
      wait_done(1'b0, 20, at);
      checks++; if (at !== 3) begin
         errors++; $display("[TB] FAIL clr_done_time got %0d exp 3", at);
      end
   endtask

   task automatic test_en_freeze();
      int at;
      s_start();
      s_bus.OUT_READY = 1'b1;
      s_load(16'd7, 16'd8, 16'd9);
      tick(); tick();
      s_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (s_bus.OUT_VALID !== 4'b0011 || s_bus.OUT_DATA !== exp_small_data(1, 7, 8, 9) || s_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL en_freeze k=%0d got %b/%h exp 0011/%h", k, s_bus.OUT_VALID, s_bus.OUT_DATA, exp_small_data(1, 7, 8, 9));
         end
      end
      s_en = 1'b1;
      for (int t = 2; t < 6; t++) begin
         tick();
         checks++; if (s_bus.OUT_VALID !== exp_v[t] || s_bus.OUT_DATA !== exp_small_data(t, 7, 8, 9)) begin
            errors++; $display("[TB] FAIL en_resume t=%0d got %b/%h exp %b/%h", t, s_bus.OUT_VALID, s_bus.OUT_DATA, exp_v[t], exp_small_data(t, 7, 8, 9));
         end
      end
      tick();
      wait_done(1'b0, 20, at);
      checks++; if (at !== 3) begin
         errors++; $display("[TB] FAIL en_done_time got %0d exp 3", at);
      end
   endtask

   task automatic test_reset_drain();
      bit seen_done;
      s_start();
      s_bus.OUT_READY = 1'b1;
      s_load(16'd1, 16'd2, 16'd3);
      for (int t = 0; t < 7; t++) tick();
      checks++; if (s_busy !== 1'b1 || s_bus.OUT_VALID !== 4'b0000) begin
         errors++; $display("[TB] FAIL drain_state got busy=%b vld=%b exp 1 0000", s_busy, s_bus.OUT_VALID);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if ({s_busy, s_done, s_bus.IN_READY, s_bus.OUT_VALID, s_row_idx} !== '0 || s_bus.OUT_DATA !== '0) begin
         errors++; $display("[TB] FAIL async_reset got busy=%b done=%b rdy=%b vld=%b exp all 0", s_busy, s_done, s_bus.IN_READY, s_bus.OUT_VALID);
      end
      tick();
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (s_done === 1'b1) seen_done = 1'b1;
      end
      checks++; if (seen_done !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_no_done got %b exp 0", seen_done);
      end
   endtask

   task automatic test_defaults();
      int beats;
      int first15;
      int at;
      logic [15:0] val15, last15;
      logic [15:0] last_v;
      do_reset();
      d_en = 1'b1;
      d_bus.OUT_READY = 1'b1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         d_bus.IN_VALID = 1'b1;
         d_bus.IN_DATA  = {16{16'(i)}};
         tick();
      end
      d_bus.IN_VALID = 1'b0;
      beats = 0; first15 = -1; val15 = '0; last15 = '0; last_v = '0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (d_bus.OUT_VALID == '0) begin
            if (beats > 0) break;
         end else begin
            if (beats == 0) begin
               checks++; if (d_bus.OUT_VALID !== 16'h0001 || d_bus.OUT_DATA[15:0] !== 16'd1) begin
                  errors++; $display("[TB] FAIL dflt_beat0 got %h/%h exp 0001/0001", d_bus.OUT_VALID, d_bus.OUT_DATA[15:0]);
               end
            end
            if (d_bus.OUT_VALID[15] && first15 < 0) begin
               first15 = beats;
               val15   = d_bus.OUT_DATA[255:240];
            end
            last_v = d_bus.OUT_VALID;
            last15 = d_bus.OUT_DATA[255:240];
            beats++;
         end
      end
      checks++; if (beats !== 23) begin
         errors++; $display("[TB] FAIL dflt_beats got %0d exp 23", beats);
      end
      checks++; if (first15 !== 15 || val15 !== 16'd1) begin
         errors++; $display("[TB] FAIL dflt_lane15_first got t=%0d val=%0d exp 15 1", first15, val15);
      end
      checks++; if (last_v !== 16'h8000 || last15 !== 16'd8) begin
         errors++; $display("[TB] FAIL dflt_last_beat got %h/%0d exp 8000/8", last_v, last15);
      end
      wait_done(1'b1, 40, at);
      checks++; if (at !== 17) begin
         errors++; $display("[TB] FAIL dflt_done_time got %0d exp 17", at);
      end
   endtask

   initial begin
      exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
      test_reset();
      test_basic_feed();
      test_stall();
      test_in_valid_toggle();
      test_clr();
      test_en_freeze();
      test_reset_drain();
      test_defaults();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Parametrised operand loader and sequencer for the systolic array.
- A host writes DEPTH rows of LANES operands through a valid/ready handshake into an internal row buffer.
- The block then streams the rows into the array with diagonal skew: lane j is delayed j beats. It honours array back-pressure, waits a programmable drain time, then pulses DONE.
- It replaces hand-driven IDX/WRITE sequencing and sits between the host/DMA and the array's DIN lanes.

Parameters:
- DATA_W, 16, operand width in bits.
- LANES, 16, array columns, i.e. parallel operand lanes.
- DEPTH, 8, rows per operand block.
- DRAIN_CYC, 16, cycles counted after the last beat before DONE.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  global enable; low freezes all state, counters and outputs.
- CLR  in  1  synchronous abort to IDLE; the buffer contents are kept.
- IN_VALID  in  1  host row valid.
- IN_READY  out  1  block accepts a row.
- IN_DATA  in  LANES*DATA_W  row; lane j occupies bits [j*DATA_W +: DATA_W].
- OUT_DATA  out  LANES*DATA_W  skewed beat to the array.
- OUT_VALID  out  LANES  per-lane valid for the current beat.
- OUT_READY  in  1  array accepts the current beat.
- ROW_IDX  out  $clog2(DEPTH)  next row slot to be written.
- BUSY  out  1  high in LOAD, FEED or DRAIN.
- DONE  out  1  one-cycle pulse at block completion.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. The buffer is not reset (contents are don't-care).
- All actions below require EN=1. With EN=0 nothing changes and outputs hold.
- CLR has priority over everything except reset.
- States:
  - IDLE -> LOAD when EN=1.
  - LOAD -> FEED when row DEPTH-1 is accepted.
  - FEED -> DRAIN when the final beat is transferred.
  - DRAIN -> DONE after DRAIN_CYC cycles.
  - DONE -> IDLE after one cycle.
- LOAD:
  - IN_READY=1.
  - Row accepted at an edge with IN_VALID&IN_READY. It is stored at buf[ROW_IDX], then ROW_IDX increments.
  - ROW_IDX wraps to 0 on leaving LOAD.
  - Zero-latency handshake: a row can be accepted every cycle.
  - IN_READY=0 in every other state; IN_VALID is ignored there.
- FEED:
  - Beat counter t runs 0..DEPTH+LANES-2, for a total of DEPTH+LANES-1 beats.
  - Beat t: lane j carries buf[t-j][j] with OUT_VALID[j]=1 when 0<=t-j<DEPTH; otherwise the lane data is 0 and OUT_VALID[j]=0.
  - OUT_DATA and OUT_VALID are registered. Beat 0 is presented in the cycle after entering FEED.
  - A beat transfers at an edge with OUT_READY=1. The next beat is loaded on that same edge, so back-to-back transfers are possible.
  - With OUT_READY=0 the beat holds unchanged.
  - After the last beat transfers, OUT_VALID=0 and OUT_DATA=0 from the next cycle.
- DRAIN: counter runs 0..DRAIN_CYC-1 and is independent of OUT_READY. DRAIN_CYC=0 goes straight to DONE.
- DONE: DONE=1 for exactly one cycle and BUSY=0. A new LOAD may start on the next cycle.
- Simultaneous events:
  - CLR during FEED: OUT_VALID=0 next cycle and no DONE.
  - CLR together with a handshake: the row is not stored.
  - EN low mid-FEED: the beat holds, and no transfer occurs even if OUT_READY=1.
- Reset mid-operation returns to the reset state immediately, without waiting for a clock edge.
- Width rules: the beat counter is $clog2(DEPTH+LANES) bits; no arithmetic is done on data.

Optional Feature:
- Macro: SA_FEED_PERF_CNT_EN.
- With the macro defined, two extra outputs exist:
  - STALL_CNT [31:0]: counts FEED cycles with OUT_VALID!=0, OUT_READY=0 and EN=1.
  - FEED_CNT [31:0]: counts total FEED cycles.
  - Both clear on entering LOAD and saturate at all-ones.
- Without the macro, neither port nor any counter logic exists.

Decomposition:
- Package sa_pkg holds:
  - the state enum typedef (IDLE, LOAD, FEED, DRAIN, DONE);
  - a lane_t typedef of logic [DATA_W-1:0] with default width 16;
  - constant SA_DEFAULT_LANES=16.
- One sub-module, sa_row_buffer: a DEPTH x LANES register array with a row write port and combinational per-lane read, where lane j reads at index t-j.

Test Plan:
- Load LANES=4, DEPTH=3, rows {1,1,1,1},{2,2,2,2},{3,3,3,3} with OUT_READY=1 -> beats t0..t5:
  - OUT_VALID = 0001, 0011, 0111, 1110, 1100, 1000;
  - t2 lane data = {lane3=0, 1, 2, 3}.
  - DONE pulses DRAIN_CYC+1 cycles after the last beat.
- Defaults with rows i=1..8 (all lanes = i) -> 23 beats; lane 15 first valid at t=15 with value 1.
- OUT_READY low for 5 cycles at t=4 -> beat 4 held for 5 cycles, the sequence is otherwise identical, and STALL_CNT=5 when the macro is enabled.
- IN_VALID toggled every other cycle in LOAD -> only handshaked rows are stored and ROW_IDX steps 0..DEPTH-1.
- CLR asserted at t=3 -> OUT_VALID=0 next cycle, state IDLE, no DONE; a reload plus feed then runs correctly.
- RST_N pulsed low mid-DRAIN -> all outputs 0 asynchronously and no DONE pulse.
